// File: rtl/inflate_pkg.sv
// inflate_pkg: shared state encodings and width helper for the inflate core.
package inflate_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOCKED = 2'd1, FLUSH = 2'd2} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority encoder, first set mask bit scanning from ptr upward modulo N.
module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] index
);
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        index = IDW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-aware round-robin arbiter for the FIFO write port,
// also sequencing a one-cycle FIFO flush.
module fifo_wr_arbiter
  import inflate_pkg::*;
#(
  parameter int N     = 2,
  parameter int WIDTH = 8,
  parameter int IDW   = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_ready,
  output logic             fifo_winc,
  output logic [WIDTH-1:0] fifo_wdata,
  input  logic             fifo_wfull,
  output logic             fifo_flush,
  input  logic             flush_req,
  output logic             flush_ack,
  output logic [IDW-1:0]   grant_id,
  output logic             busy
);
  state_t state, state_n;
  logic [IDW-1:0] rr_ptr, rr_ptr_n, lock_id, lock_id_n, cand, ptr, cand_inc;
  logic [N-1:0] mask;
  logic found, ready;
  // While locked, only the lock holder may be picked, and only when it is valid.
  assign mask = (state == LOCKED) ? (req_valid & (N'(1) << lock_id)) : req_valid;
  assign ptr  = (state == LOCKED) ? lock_id : rr_ptr;
  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .mask  (mask),
    .ptr   (ptr),
    .found (found),
    .index (cand)
  );
  // Outputs are gated by rst_n so nothing leaks to the FIFO during a reset cycle.
  assign ready      = rst_n & found & !fifo_wfull & !flush_req & (state != FLUSH);
  assign req_ready  = ready ? (N'(1) << cand) : '0;
  assign fifo_winc  = ready;
  assign fifo_wdata = ready ? req_data[cand*WIDTH +: WIDTH] : '0;
  assign grant_id   = ready ? cand : '0;
  assign fifo_flush = rst_n & (state == FLUSH);
  assign flush_ack  = fifo_flush;
  assign busy       = rst_n & (state == LOCKED);
  assign cand_inc   = (cand == IDW'(N - 1)) ? '0 : cand + 1'b1;
  always_comb begin
    state_n   = state;
    rr_ptr_n  = rr_ptr;
    lock_id_n = lock_id;
    if (state == FLUSH) begin
      state_n   = IDLE;
      rr_ptr_n  = '0;
      lock_id_n = '0;
    end else if (flush_req) begin
      state_n = FLUSH;
    end else if (ready) begin
      state_n   = req_last[cand] ? IDLE : LOCKED;
      rr_ptr_n  = req_last[cand] ? cand_inc : rr_ptr;
      lock_id_n = req_last[cand] ? lock_id : cand;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else begin
      state   <= state_n;
      rr_ptr  <= rr_ptr_n;
      lock_id <= lock_id_n;
    end
  end
endmodule
